// File: rtl/cacheline_adaptor_pkg.sv
// cacheline_adaptor_pkg: shared state encoding, default widths and beat-count helper for cacheline_adaptor.
package cacheline_adaptor_pkg;
  typedef enum logic [1:0] {IDLE, RD, WR, DONE} cla_state_t;
  localparam int CLA_LINE_W = 256;
  localparam int CLA_BEAT_W = 64;
  localparam int CLA_ADDR_W = 32;
  function automatic int beats(input int line_w, input int beat_w);
    return line_w / beat_w;
  endfunction
endpackage

// File: rtl/cacheline_adaptor.sv
// cacheline_adaptor: converts cache line reads/writes into BEATS-long memory bursts and back.
// Optional CACHELINE_ADAPTOR_PERF_EN adds rd_lines_o/wr_lines_o completed-line counters.
module cacheline_adaptor
  import cacheline_adaptor_pkg::*;
#(
  parameter int LINE_W = CLA_LINE_W,
  parameter int BEAT_W = CLA_BEAT_W,
  parameter int ADDR_W = CLA_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [LINE_W-1:0] line_i,
  output logic [LINE_W-1:0] line_o,
  input  logic [ADDR_W-1:0] address_i,
  input  logic              read_i,
  input  logic              write_i,
  output logic              resp_o,
  input  logic [BEAT_W-1:0] burst_i,
  output logic [BEAT_W-1:0] burst_o,
  output logic [ADDR_W-1:0] address_o,
  output logic              read_o,
  output logic              write_o,
  input  logic              resp_i
`ifdef CACHELINE_ADAPTOR_PERF_EN
  ,
  output logic [31:0]       rd_lines_o,
  output logic [31:0]       wr_lines_o
`endif
);
  localparam int BEATS = beats(LINE_W, BEAT_W);
  localparam int OFF_W = $clog2(LINE_W / 8);
  localparam int CNT_W = $clog2(BEATS);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(BEATS - 1);
  cla_state_t state, state_n;
  logic [CNT_W-1:0] count;
  logic [LINE_W-1:0] line_buf;
  logic accept, beat, unused_addr;
  assign accept = state == IDLE && (read_i || write_i);
  assign beat = resp_i && (state == RD || state == WR);
  assign unused_addr = ^address_i[OFF_W-1:0];
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = read_i ? RD : write_i ? WR : IDLE;
      RD, WR:  state_n = beat && count == LAST ? DONE : state;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      count     <= '0;
      line_buf  <= '0;
      address_o <= '0;
    end else begin
      state <= state_n;
      if (accept) begin
        address_o <= {address_i[ADDR_W-1:OFF_W], OFF_W'(0)};
        count     <= '0;
      end else if (beat && count != LAST) count <= count + 1'b1;
      if (state == RD && resp_i) line_buf[int'(count)*BEAT_W +: BEAT_W] <= burst_i;
    end
  end
  assign read_o  = state == RD;
  assign write_o = state == WR;
  assign resp_o  = state == DONE;
  assign line_o  = line_buf;
  assign burst_o = state == WR ? line_i[int'(count)*BEAT_W +: BEAT_W] : '0;
`ifdef CACHELINE_ADAPTOR_PERF_EN
  // Remembers the direction of the transfer so DONE can be attributed.
  logic was_rd;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      was_rd     <= 1'b0;
      rd_lines_o <= '0;
      wr_lines_o <= '0;
    end else begin
      if (accept) was_rd <= read_i;
      if (state == DONE && was_rd) rd_lines_o <= rd_lines_o + 1'b1;
      if (state == DONE && !was_rd) wr_lines_o <= wr_lines_o + 1'b1;
    end
  end
`endif
endmodule

// File: tb/tb_cacheline_adaptor.sv
// tb_cacheline_adaptor: vector table, hand-written corner sequences and random transfers for cacheline_adaptor.
module tb_cacheline_adaptor;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [255:0] line_i = '0, line_o;
  logic [31:0] address_i = '0, address_o;
  logic read_i = 1'b0, write_i = 1'b0, resp_o, read_o, write_o, resp_i = 1'b0;
  logic [63:0] burst_i = '0, burst_o;
`ifdef CACHELINE_ADAPTOR_PERF_EN
  logic [31:0] rd_lines_o, wr_lines_o;
`endif
  int passed = 0, total = 0;
  logic [255:0] prev_line = '0;
  int exp_rd = 0, exp_wr = 0;

  cacheline_adaptor dut (
    .clk(clk), .rst_n(rst_n), .line_i(line_i), .line_o(line_o), .address_i(address_i),
    .read_i(read_i), .write_i(write_i), .resp_o(resp_o), .burst_i(burst_i), .burst_o(burst_o),
    .address_o(address_o), .read_o(read_o), .write_o(write_o), .resp_i(resp_i)
`ifdef CACHELINE_ADAPTOR_PERF_EN
    , .rd_lines_o(rd_lines_o), .wr_lines_o(wr_lines_o)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  typedef struct {
    bit           wr;
    logic [31:0]  addr;
    logic [31:0]  exp_addr;
    logic [255:0] data;
    logic [15:0]  pat;
  } vec_t;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h required %0h", name, act, exp);
  endtask

  function automatic logic [255:0] rnd_line();
    return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
  endfunction

  // Entered at the first negedge where the burst request should be visible.
  task automatic run(input bit wr, input logic [31:0] exp_addr, input logic [255:0] data,
                     input logic [15:0] pat, input bit drop);
    int beat = 0, i = 0;
    bit r;
    chk("busy_start", wr ? write_o : read_o, 1);
    while (beat < 4 && i < 64) begin
      r = (i >= 16) ? 1'b1 : pat[i];
      resp_i = r;
      burst_i = wr ? 64'($urandom) : data[beat*64 +: 64];
      if (wr) chk("burst_o", burst_o, data[beat*64 +: 64]);
      chk("address_o", address_o, exp_addr);
      chk("busy", wr ? write_o : read_o, 1);
      chk("resp_o_early", resp_o, 0);
      @(negedge clk);
      if (r) beat++;
      i++;
    end
    resp_i = 1'b0;
    chk("resp_o_done", resp_o, 1);
    chk("rw_o_done", {read_o, write_o}, 0);
    if (!wr) prev_line = data;
    chk("line_o", line_o, prev_line);
    if (wr) exp_wr++; else exp_rd++;
    if (drop) begin read_i = 1'b0; write_i = 1'b0; end
  endtask

  task automatic xfer(input bit wr, input logic [31:0] addr, input logic [255:0] data, input logic [15:0] pat);
    @(negedge clk);
    read_i = !wr; write_i = wr; address_i = addr;
    if (wr) line_i = data;
    @(negedge clk);
    run(wr, {addr[31:5], 5'd0}, data, pat, 1'b1);
    @(negedge clk);
    chk("resp_o_pulse", resp_o, 0);
  endtask

  vec_t vecs[6];

  initial begin
    logic [255:0] rd_spec, wr_spec, d;
    logic [31:0] a;
    bit seen;
    rd_spec = {{4{16'h4444}}, {4{16'h3333}}, {4{16'h2222}}, {4{16'h1111}}};
    wr_spec = {64'hD3D3_0003_DEAD_BEEF, 64'hD2D2_0002_CAFE_F00D, 64'hD1D1_0001_0BAD_C0DE, 64'hD0D0_0000_1234_5678};
    vecs[0] = '{0, 32'h1234_567F, 32'h1234_5660, rd_spec, 16'hFFFF};
    vecs[1] = '{1, 32'h0000_1001, 32'h0000_1000, wr_spec, 16'b101101};
    vecs[2] = '{0, 32'hFFFF_FFFF, 32'hFFFF_FFE0, {4{64'h0123_4567_89AB_CDEF}}, 16'b0101_0101_0101};
    vecs[3] = '{1, 32'h0000_001F, 32'h0000_0000, {256{1'b1}}, 16'hFFFF};
    vecs[4] = '{0, 32'h8000_0020, 32'h8000_0020, {64'hA, 64'hB, 64'hC, 64'hD}, 16'b1110_0000_0000_0001};
    vecs[5] = '{1, 32'h7FFF_FFC5, 32'h7FFF_FFC0, {64'h1, 64'h2, 64'h3, 64'h4}, 16'b0000_0000_0001_0000};

    // Reset held with a pending read: everything stays zero.
    read_i = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_outs", {resp_o, read_o, write_o, address_o, burst_o}, 0);
    chk("rst_line", line_o, 0);
    rst_n = 1'b1;
    seen = 0;
    for (int k = 0; k < 2 && !seen; k++) begin
      @(negedge clk);
      seen = read_o;
    end
    chk("read_after_rst", seen, 1);
    run(0, 32'h0, rnd_line(), 16'hFFFF, 1'b1);
    @(negedge clk);

    // Table-driven transfers.
    for (int v = 0; v < 6; v++) begin
      @(negedge clk);
      read_i = !vecs[v].wr; write_i = vecs[v].wr; address_i = vecs[v].addr;
      if (vecs[v].wr) line_i = vecs[v].data;
      @(negedge clk);
      run(vecs[v].wr, vecs[v].exp_addr, vecs[v].data, vecs[v].pat, 1'b1);
      @(negedge clk);
      chk("vec_pulse", resp_o, 0);
    end

    // resp_i while idle must not move anything.
    resp_i = 1'b1; burst_i = 64'hBAD0_BAD0_BAD0_BAD0;
    repeat (3) begin
      @(negedge clk);
      chk("idle_ignore", {resp_o, read_o, write_o}, 0);
      chk("idle_line", line_o, prev_line);
    end
    resp_i = 1'b0;

    // Simultaneous read and write: read first, write follows from IDLE.
    d = rnd_line();
    @(negedge clk);
    read_i = 1'b1; write_i = 1'b1; address_i = 32'h0000_ABCD; line_i = wr_spec;
    @(negedge clk);
    run(0, 32'h0000_ABC0, d, 16'hFFFF, 1'b0);
    read_i = 1'b0;
    @(negedge clk);
    chk("both_idle", {resp_o, read_o, write_o}, 0);
    @(negedge clk);
    run(1, 32'h0000_ABC0, wr_spec, 16'b1011, 1'b1);
    @(negedge clk);
    chk("both_pulse", resp_o, 0);

    // Reset after two beats of a read aborts it.
    @(negedge clk);
    read_i = 1'b1; address_i = 32'h0000_4444;
    @(negedge clk);
    resp_i = 1'b1; burst_i = 64'h5555;
    @(negedge clk);
    burst_i = 64'h6666;
    @(negedge clk);
    resp_i = 1'b0; read_i = 1'b0; rst_n = 1'b0;
    #1;
    chk("abort_outs", {resp_o, read_o, write_o, address_o}, 0);
    chk("abort_line", line_o, 0);
    prev_line = '0; exp_rd = 0; exp_wr = 0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) begin
      @(negedge clk);
      chk("abort_no_resp", {resp_o, read_o}, 0);
    end
    xfer(0, 32'h0000_4444, rd_spec, 16'b1101);

    // Random transfers against the line/beat model.
    for (int n = 0; n < 24; n++) begin
      a = $urandom;
      xfer(1'($urandom_range(1)), a, rnd_line(), 16'($urandom));
    end

`ifdef CACHELINE_ADAPTOR_PERF_EN
    chk("rd_lines_o", rd_lines_o, 256'(exp_rd));
    chk("wr_lines_o", wr_lines_o, 256'(exp_wr));
`endif
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
